dvs_event_sequencer: RTL and testbench



---
 rtl/dvs_event_sequencer_if.sv | 22 ++
 rtl/dvs_event_sequencer.sv | 149 ++++++++++++++
 tb/tb_dvs_event_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvs_event_sequencer_if.sv
// Receiver-side AER word strobe and consumer-side event handshake for the DVS event sequencer.
interface dvs_event_sequencer_if;
    localparam int unsigned AER_W = 10;
    localparam int unsigned EVT_W = 20;

    logic             rx_valid;
    logic [AER_W-1:0] rx_aer;
    logic             rx_xsel;
    logic [EVT_W-1:0] evt_data;
    logic             evt_valid;
    logic             evt_ready;

    modport master (
        output rx_valid, rx_aer, rx_xsel, evt_ready,
        input  evt_data, evt_valid
    );

    modport slave (
        input  rx_valid, rx_aer, rx_xsel, evt_ready,
        output evt_data, evt_valid
    );
endinterface

// File: rtl/dvs_event_sequencer.sv
// Pairs AER X words with the latest Y row, queues {pol, y, x} events in a show-ahead FIFO
// and keeps saturating drop/orphan statistics.
module dvs_event_sequencer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         clr_stats,
    dvs_event_sequencer_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [CNT_W-1:0]             drop_count,
    output logic [CNT_W-1:0]             orphan_count,
    output logic                         overflow
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned AER_W = 10;
    localparam int unsigned EVT_W = 20;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        NO_ROW   = 1'b0,
        HAVE_ROW = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [AER_W-1:0]   r_row, w_row_nxt;
    logic               w_push;
    logic               w_orphan;
    logic [EVT_W-1:0]   w_evt;

    logic [EVT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr, w_rptr_inc;
    logic [LVL_W-1:0]   r_level, w_level_nxt;
    logic [EVT_W-1:0]   r_head, w_head_nxt;
    logic               r_valid;
    logic               w_full, w_pop, w_wr, w_drop;

    logic [CNT_W-1:0]   r_drop_cnt, r_orphan_cnt;
    logic               r_overflow;

    assign w_evt = {bus.rx_aer[0], r_row, bus.rx_aer[AER_W-1:1]};

    // Row tracking state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NO_ROW;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_push      = 1'b0;
        w_orphan    = 1'b0;
        if (!enable) begin
            w_state_nxt = NO_ROW;
        end else if (bus.rx_valid) begin
            case (r_state)
                NO_ROW: begin
                    if (bus.rx_xsel) begin
                        w_orphan = 1'b1;
                    end else begin
                        w_row_nxt   = bus.rx_aer;
                        w_state_nxt = HAVE_ROW;
                    end
                end
                HAVE_ROW: begin
                    if (bus.rx_xsel) w_push    = 1'b1;
                    else             w_row_nxt = bus.rx_aer;
                end
                default: w_state_nxt = NO_ROW;
            endcase
        end
    end

    // Fullness uses the pre-edge level, so a same-cycle pop never rescues a push
    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_pop      = (r_level != '0) && bus.evt_ready;
    assign w_wr       = w_push && !w_full;
    assign w_drop     = w_push && w_full;
    assign w_rptr_inc = r_rptr + PTR_W'(1);

    // Head is pre-registered so evt_data comes straight from a flop
    always_comb begin
        w_level_nxt = r_level;
        w_head_nxt  = r_head;
        if (w_wr && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
        else if (!w_wr && w_pop) w_level_nxt = r_level - LVL_W'(1);

        if (w_pop) begin
            if (r_level > LVL_W'(1)) w_head_nxt = r_mem[w_rptr_inc];
            else if (w_wr)           w_head_nxt = w_evt;
        end else if ((r_level == '0) && w_wr) begin
            w_head_nxt = w_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop) r_rptr <= w_rptr_inc;
            r_level <= w_level_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_level_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_evt;
    end

    // Saturating statistics; a same-cycle event wins over clr_stats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt   <= '0;
            r_orphan_cnt <= '0;
            r_overflow   <= 1'b0;
        end else if (clr_stats) begin
            r_drop_cnt   <= CNT_W'(w_drop);
            r_orphan_cnt <= CNT_W'(w_orphan);
            r_overflow   <= w_drop;
        end else begin
            if (w_drop && (r_drop_cnt != CNT_MAX))     r_drop_cnt   <= r_drop_cnt + CNT_W'(1);
            if (w_orphan && (r_orphan_cnt != CNT_MAX)) r_orphan_cnt <= r_orphan_cnt + CNT_W'(1);
            if (w_drop)                                r_overflow   <= 1'b1;
        end
    end

    assign bus.evt_data  = r_head;
    assign bus.evt_valid = r_valid;
    assign fifo_level    = r_level;
    assign drop_count    = r_drop_cnt;
    assign orphan_count  = r_orphan_cnt;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_dvs_event_sequencer.sv
// Randomized and directed bench for dvs_event_sequencer against a queue-based event model.
module tb_dvs_event_sequencer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clr_stats = 1'b0;
    logic [3:0]       fifo_level;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] orphan_count;
    logic             overflow;

    dvs_event_sequencer_if u_if ();

    dvs_event_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clr_stats    (clr_stats),
        .bus          (u_if.slave),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .orphan_count (orphan_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [19:0]      m_q [$];
    bit               m_have_row;
    logic [9:0]       m_row;
    logic [CNT_W-1:0] m_drop;
    logic [CNT_W-1:0] m_orph;
    bit               m_ovf;

    function automatic logic [9:0] xw(input int x, input bit p);
        return {9'(x), p};
    endfunction

    function automatic logic [19:0] ev(input bit p, input int y, input int x);
        return {p, 10'(y), 9'(x)};
    endfunction

    // Apply one cycle of inputs at a falling edge, advance the model, stop at the next falling edge
    task automatic cycle(input bit en, input bit clr, input bit v, input logic [9:0] aer,
                         input bit xs, input bit rdy);
        int lvl;
        bit pop, push, orph, drop;
        logic [19:0] e;
        enable          = en;
        clr_stats       = clr;
        u_if.rx_valid   = v;
        u_if.rx_aer     = aer;
        u_if.rx_xsel    = xs;
        u_if.evt_ready  = rdy;
        lvl  = m_q.size();
        pop  = (lvl > 0) && rdy;
        push = en && v && xs && m_have_row;
        orph = en && v && xs && !m_have_row;
        drop = push && (lvl == DEPTH);
        e    = {aer[0], m_row, aer[9:1]};
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(e);
        if (!en) m_have_row = 1'b0;
        else if (v && !xs) begin
            m_have_row = 1'b1;
            m_row      = aer;
        end
        if (clr) begin
            m_drop = drop ? 16'd1 : 16'd0;
            m_orph = orph ? 16'd1 : 16'd0;
            m_ovf  = drop;
        end else begin
            if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            if (orph && m_orph != 16'hFFFF) m_orph = m_orph + 16'd1;
            if (drop) m_ovf = 1'b1;
        end
        @(negedge clk);
        u_if.rx_valid = 1'b0;
        clr_stats     = 1'b0;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, rdy);
    endtask

    task automatic hit_reset();
        rst_n = 1'b0;
        m_q.delete();
        m_have_row = 1'b0;
        m_row  = '0;
        m_drop = '0;
        m_orph = '0;
        m_ovf  = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        hit_reset();
        checks += 6;
        if (u_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", u_if.evt_valid); end
        if (u_if.evt_data !== 20'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", u_if.evt_data); end
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        if (orphan_count !== 16'd0) begin errors++; $display("FAIL reset_orphan: got %0d expected 0", orphan_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        release_reset();
    endtask

    task automatic test_basic();
        logic [19:0] exp_e;
        exp_e = {1'b1, 10'h155, 9'h051};
        cycle(1'b1, 1'b0, 1'b1, 10'h155, 1'b0, 1'b1);
        checks++;
        if (u_if.evt_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_valid: got %b expected 0", u_if.evt_valid); end
        cycle(1'b1, 1'b0, 1'b1, 10'h0A3, 1'b1, 1'b1);
        checks += 3;
        if (u_if.evt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", u_if.evt_valid); end
        if (u_if.evt_data !== exp_e) begin errors++; $display("FAIL basic_data: got %h expected %h", u_if.evt_data, exp_e); end
        if (fifo_level !== 4'd1) begin errors++; $display("FAIL basic_level: got %0d expected 1", fifo_level); end
        idle(1'b1);
        checks += 2;
        if (u_if.evt_valid !== 1'b0) begin errors++; $display("FAIL basic_drained_valid: got %b expected 0", u_if.evt_valid); end
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL basic_drained_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_row();
        logic [19:0] exp_e [3];
        exp_e[0] = ev(1'b0, 5, 1);
        exp_e[1] = ev(1'b1, 5, 2);
        exp_e[2] = ev(1'b0, 9, 3);
        hit_reset();
        release_reset();
        cycle(1'b1, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, xw(1, 1'b0), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, xw(2, 1'b1), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 10'd9, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, xw(3, 1'b0), 1'b1, 1'b0);
        checks++;
        if (fifo_level !== 4'd3) begin errors++; $display("FAIL row_level: got %0d expected 3", fifo_level); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (u_if.evt_data !== exp_e[i]) begin errors++; $display("FAIL row_event%0d: got %h expected %h", i, u_if.evt_data, exp_e[i]); end
            idle(1'b1);
        end
        checks++;
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL row_drained: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_orphan();
        hit_reset();
        release_reset();
        cycle(1'b1, 1'b0, 1'b1, 10'h010, 1'b1, 1'b1);
        checks += 2;
        if (orphan_count !== 16'd1) begin errors++; $display("FAIL orphan_first: got %0d expected 1", orphan_count); end
        if (u_if.evt_valid !== 1'b0) begin errors++; $display("FAIL orphan_no_event: got %b expected 0", u_if.evt_valid); end
        cycle(1'b1, 1'b0, 1'b1, 10'd3, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 10'h010, 1'b1, 1'b1);
        checks++;
        if (orphan_count !== 16'd1) begin errors++; $display("FAIL orphan_disabled_ignored: got %0d expected 1", orphan_count); end
        cycle(1'b1, 1'b0, 1'b1, 10'h010, 1'b1, 1'b1);
        checks += 2;
        if (orphan_count !== 16'd2) begin errors++; $display("FAIL orphan_second: got %0d expected 2", orphan_count); end
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL orphan_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_full();
        logic [19:0] exp_e;
        hit_reset();
        release_reset();
        cycle(1'b1, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, xw(i, i[0]), 1'b1, 1'b0);
        exp_e = ev(1'b0, 1, 0);
        checks += 4;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d expected 8", fifo_level); end
        if (drop_count !== 16'd2) begin errors++; $display("FAIL full_drop: got %0d expected 2", drop_count); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b expected 1", overflow); end
        if (u_if.evt_data !== exp_e) begin errors++; $display("FAIL full_head: got %h expected %h", u_if.evt_data, exp_e); end
        idle(1'b0);
        checks += 2;
        if (u_if.evt_data !== exp_e) begin errors++; $display("FAIL full_hold_data: got %h expected %h", u_if.evt_data, exp_e); end
        if (u_if.evt_valid !== 1'b1) begin errors++; $display("FAIL full_hold_valid: got %b expected 1", u_if.evt_valid); end
        cycle(1'b1, 1'b0, 1'b1, xw(10, 1'b0), 1'b1, 1'b1);
        checks += 2;
        if (fifo_level !== 4'd7) begin errors++; $display("FAIL full_pop_level: got %0d expected 7", fifo_level); end
        if (drop_count !== 16'd3) begin errors++; $display("FAIL full_pop_drop: got %0d expected 3", drop_count); end
        for (int i = 1; i < 8; i++) begin
            exp_e = ev(i[0], 1, i);
            checks++;
            if (u_if.evt_data !== exp_e) begin errors++; $display("FAIL full_drain%0d: got %h expected %h", i, u_if.evt_data, exp_e); end
            idle(1'b1);
        end
        checks++;
        if (u_if.evt_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", u_if.evt_valid); end
    endtask

    task automatic test_stats();
        hit_reset();
        release_reset();
        cycle(1'b1, 1'b0, 1'b1, 10'd7, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, xw(i, 1'b1), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, xw(20, 1'b1), 1'b1, 1'b0);
        checks++;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL stats_pre: got %0d expected 2", drop_count); end
        cycle(1'b1, 1'b1, 1'b1, xw(21, 1'b0), 1'b1, 1'b0);
        checks += 2;
        if (drop_count !== 16'd1) begin errors++; $display("FAIL stats_clr_drop: got %0d expected 1", drop_count); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL stats_clr_ovf: got %b expected 1", overflow); end
        cycle(1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        checks += 3;
        if (drop_count !== 16'd0) begin errors++; $display("FAIL stats_clr_only: got %0d expected 0", drop_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL stats_clr_ovf0: got %b expected 0", overflow); end
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL stats_fifo_kept: got %0d expected 8", fifo_level); end
        hit_reset();
        release_reset();
        cycle(1'b1, 1'b0, 1'b1, 10'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, xw(i, 1'b0), 1'b1, 1'b0);
        checks++;
        if (fifo_level !== 4'd3) begin errors++; $display("FAIL stats_three: got %0d expected 3", fifo_level); end
        hit_reset();
        checks += 2;
        if (u_if.evt_valid !== 1'b0) begin errors++; $display("FAIL stats_rst_valid: got %b expected 0", u_if.evt_valid); end
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL stats_rst_level: got %0d expected 0", fifo_level); end
        release_reset();
    endtask

    task automatic test_random();
        int rdy_pct;
        hit_reset();
        release_reset();
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) rdy_pct = $urandom_range(0, 100);
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 1) == 1, 10'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(1, 100) <= rdy_pct);
            checks += 5;
            if (u_if.evt_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", n, u_if.evt_valid, m_q.size() != 0); end
            if (fifo_level !== 4'(m_q.size())) begin errors++; $display("FAIL rand_level@%0d: got %0d expected %0d", n, fifo_level, m_q.size()); end
            if (drop_count !== m_drop) begin errors++; $display("FAIL rand_drop@%0d: got %0d expected %0d", n, drop_count, m_drop); end
            if (orphan_count !== m_orph) begin errors++; $display("FAIL rand_orphan@%0d: got %0d expected %0d", n, orphan_count, m_orph); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf@%0d: got %b expected %b", n, overflow, m_ovf); end
            if (m_q.size() != 0) begin
                checks++;
                if (u_if.evt_data !== m_q[0]) begin errors++; $display("FAIL rand_data@%0d: got %h expected %h", n, u_if.evt_data, m_q[0]); end
            end
        end
    endtask

    initial begin
        u_if.rx_valid  = 1'b0;
        u_if.rx_aer    = '0;
        u_if.rx_xsel   = 1'b0;
        u_if.evt_ready = 1'b0;
        test_reset();
        test_basic();
        test_row();
        test_orphan();
        test_full();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
